fetch_line_ctrl: RTL and testbench
==================================

# fetch_line_ctrl

Sequences 64 B instruction-line refills from local store (LS) into the IF line buffer, and shares the single LS read port between the instruction fetch and load/store (LSU) requesters. Instruction fetch raises a refill request or a redirect with a word PC. The block issues four 128-bit quadword reads, writes them into the line buffer, and then flags the line valid. LSU has priority on the port, with a starvation bound that guarantees refill progress.

## Interface
- PC_W, 8, width of instruction word address (PC)
- STARVE_MAX, 8, consecutive refill-stall cycles after which fetch overrides LSU priority
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- fetch_req  in  1  IF refill request pulse, sampled with fetch_pc
- fetch_pc  in  PC_W  word address; line base = {fetch_pc[PC_W-1:4], 4'b0}
- flush  in  1  redirect: abort any refill, restart at fetch_pc; dominates fetch_req
- lsu_req  in  1  LSU read request, held until granted
- lsu_qaddr  in  PC_W-2  LSU quadword address
- lsu_gnt  out  1  LSU owns LS port this cycle
- lsu_rvalid  out  1  ls_rd_data belongs to LSU (1 cycle after lsu_gnt)
- ls_rd_en  out  1  LS read strobe
- ls_rd_addr  out  PC_W-2  LS quadword address
- ls_rd_data  in  128  LS read data, valid 1 cycle after ls_rd_en
- line_wr_en  out  1  write one quadword into line buffer
- line_wr_idx  out  2  quadword slot 0..3 (words 4*idx..4*idx+3)
- line_wr_data  out  128  = ls_rd_data
- line_valid  out  1  line buffer holds a complete line at line_base
- line_base  out  PC_W  word address of buffered line
- busy  out  1  refill in progress

## Operation
- States: IDLE, FILL, DRAIN. Reset → IDLE, all outputs 0, pending cleared, starve counter 0.
- IDLE + fetch_req/flush: latch line base, clear line_valid, go FILL, issue_cnt=0.
- FILL: each cycle the port goes to exactly one requester. LSU wins if lsu_req && starve_cnt<STARVE_MAX. Otherwise fetch issues beat issue_cnt at addr base[PC_W-1:2]+issue_cnt.
- After beat 3 is issued, go DRAIN. DRAIN still grants LSU.
- Return pipeline: 1-bit valid + 2-bit idx register. When it is valid, line_wr_en=1 and line_wr_idx=idx.
- Completion: when the idx=3 write occurs, line_valid<=1 and line_base<=base. Go IDLE, or go FILL if pending is set.
- IDLE + lsu_req: grant immediately.
- starve_cnt increments in FILL on each LSU-won cycle and clears on each fetch beat. It saturates at STARVE_MAX.
- fetch_req while busy (no flush): stored in a one-entry pending register, newest overwrites. It is serviced right after completion.
- flush in any state: clears pending, line_valid and return pipeline valid (in-flight fetch data discarded, no write). Latches new base, goes FILL with issue_cnt=0.
- In-flight LSU data is unaffected by flush; lsu_rvalid still fires.
- Refill to the same line as line_base still re-fills (no hit check).

## Timing
- Registered control: fetch_req at cycle 0 with no LSU traffic → ls_rd_en cycles 1–4 (quadword addrs base/4+0..3). line_wr_en cycles 2–5, idx 0..3. line_valid=1 from cycle 6. busy cycles 1–5.
- lsu_gnt, ls_rd_en and ls_rd_addr are combinational from state/inputs within a cycle. lsu_rvalid and line_wr_en are registered.
- Each LSU-won cycle during FILL delays remaining beats by one cycle.
- Worst-case refill latency = 6 + 4*STARVE_MAX cycles.
- reset assertion mid-refill: immediate return to IDLE, line_valid=0, no further writes.
- ls_rd_addr arithmetic is modulo 2^(PC_W-2). Line base never crosses a line, so no wrap inside a line.

## Structure
- Shared SPU package: fl_state_t enum {IDLE, FILL, DRAIN}, LINE_QW=4, QW_BITS=128.
- One sub-module is natural: ls_port_arb. It covers the 2-way priority arbiter with the starvation counter, outputs the grant and holds the starve_cnt register.
- The FSM, issue counter, return pipeline and pending register stay in fetch_line_ctrl.

## Test plan
- Reset, fetch_req pc=8'h13: reads qaddr 4,5,6,7 on cycles 1–4; writes idx 0–3 on cycles 2–5; line_valid=1, line_base=8'h10 on cycle 6.
- Refill of pc=0 with lsu_req held high, STARVE_MAX=8: LSU granted 8 cycles, then one fetch beat. Pattern repeats; line_valid at cycle 6+32; lsu_rvalid follows every lsu_gnt by 1.
- flush pc=8'h40 during cycle 3 of refill at pc=0: no line_wr_en for the old data after cycle 3. Reads qaddr 16..19 follow; line_base=8'h40.
- fetch_req pc=8'h20, then pc=8'h30 while busy: after the 8'h20 line completes, the 8'h30 refill starts next cycle; line_base=8'h30 at end.
- Async reset deasserted→asserted mid-DRAIN: all outputs 0 immediately. After release, idle until a new request.
- lsu_req in IDLE with qaddr 6'h2A: lsu_gnt=1 and ls_rd_addr=6'h2A the same cycle; lsu_rvalid next cycle; line_wr_en stays 0.

Source files
------------

// File: rtl/fetch_line_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// fetch_line_ctrl_pkg : shared types and sizes for the IF line refill slice
// Revision: 1.0
// ============================================================================
package fetch_line_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } fl_state_t;

  localparam int LINE_QW    = 4;
  localparam int QW_BITS    = 128;
  localparam int IDX_W      = $clog2(LINE_QW);
  // 16 words per line: low word-address bits that select a word inside a line
  localparam int LINE_OFS_W = 4;

endpackage
`default_nettype wire

// File: rtl/ls_port_arb.sv
`default_nettype none
// ============================================================================
// ls_port_arb : LSU-priority arbiter for the LS read port with a starvation
//               bound that forces a fetch beat after STARVE_MAX LSU wins.
// Revision: 1.0
// ============================================================================
module ls_port_arb
  import fetch_line_ctrl_pkg::*;
#(
  parameter int STARVE_MAX = 8
) (
  input  logic      clk,
  input  logic      reset,
  input  fl_state_t state,
  input  logic      lsu_req,
  output logic      lsu_gnt,
  output logic      fetch_gnt
);

  localparam int                 c_CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [c_CNT_W-1:0] c_MAX   = c_CNT_W'(STARVE_MAX);

  logic [c_CNT_W-1:0] r_starve_cnt;
  logic               w_fill;
  logic               w_starved;

  assign w_fill    = (state == FILL);
  assign w_starved = w_fill && (r_starve_cnt >= c_MAX);

  // Grant is gated by reset so the port is silent the moment reset asserts.
  assign lsu_gnt   = reset && lsu_req && !w_starved;
  assign fetch_gnt = w_fill && !lsu_gnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_starve_cnt <= '0;
    end else if (w_fill) begin
      if (fetch_gnt) begin
        r_starve_cnt <= '0;
      end else if (r_starve_cnt < c_MAX) begin
        r_starve_cnt <= r_starve_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fetch_line_ctrl.sv
`default_nettype none
// ============================================================================
// fetch_line_ctrl : sequences 64 B instruction-line refills from local store
//                   into the IF line buffer, sharing the LS port with LSU.
// Revision: 1.0
// ============================================================================
module fetch_line_ctrl
  import fetch_line_ctrl_pkg::*;
#(
  parameter int PC_W       = 8,
  parameter int STARVE_MAX = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fetch_req,
  input  logic [PC_W-1:0]    fetch_pc,
  input  logic               flush,
  input  logic               lsu_req,
  input  logic [PC_W-3:0]    lsu_qaddr,
  output logic               lsu_gnt,
  output logic               lsu_rvalid,
  output logic               ls_rd_en,
  output logic [PC_W-3:0]    ls_rd_addr,
  input  logic [QW_BITS-1:0] ls_rd_data,
  output logic               line_wr_en,
  output logic [IDX_W-1:0]   line_wr_idx,
  output logic [QW_BITS-1:0] line_wr_data,
  output logic               line_valid,
  output logic [PC_W-1:0]    line_base,
  output logic               busy
);

  localparam int               c_QA_W     = PC_W - 2;
  localparam int               c_TAG_W    = PC_W - LINE_OFS_W;
  localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(LINE_QW - 1);

  fl_state_t          r_state;
  fl_state_t          w_state_nxt;

  logic [c_TAG_W-1:0] r_base_tag;
  logic [c_TAG_W-1:0] r_line_tag;
  logic [c_TAG_W-1:0] r_pend_tag;
  logic [c_TAG_W-1:0] w_pend_tag;
  logic [c_TAG_W-1:0] w_start_tag;
  logic [c_TAG_W-1:0] w_fetch_tag;
  logic               r_pend_v;
  logic               w_pend_any;
  logic               w_req_busy;

  logic [IDX_W-1:0]   r_issue_cnt;
  logic [IDX_W-1:0]   r_ridx;
  logic               r_rv;
  logic               r_lsu_rv;
  logic               r_line_valid;

  logic               w_start;
  logic               w_complete;
  logic               w_lsu_gnt;
  logic               w_fetch_gnt;
  logic [c_QA_W-1:0]  w_fetch_qaddr;
  logic               w_unused_pc_ofs;

  // Word offset within the line only matters to IF, not to the refill.
  assign w_unused_pc_ofs = ^fetch_pc[LINE_OFS_W-1:0];
  assign w_fetch_tag     = fetch_pc[PC_W-1:LINE_OFS_W];

  ls_port_arb #(
    .STARVE_MAX (STARVE_MAX)
  ) u_ls_port_arb (
    .clk       (clk),
    .reset     (reset),
    .state     (r_state),
    .lsu_req   (lsu_req),
    .lsu_gnt   (w_lsu_gnt),
    .fetch_gnt (w_fetch_gnt)
  );

  // Lines are aligned, so the beat index is just the low quadword bits.
  assign w_fetch_qaddr = {r_base_tag, r_issue_cnt};
  assign w_complete    = r_rv && (r_ridx == c_LAST_IDX);
  assign w_req_busy    = fetch_req && (r_state != IDLE);
  assign w_pend_any    = r_pend_v || w_req_busy;
  assign w_pend_tag    = fetch_req ? w_fetch_tag : r_pend_tag;

  assign lsu_gnt      = w_lsu_gnt;
  assign ls_rd_en     = w_lsu_gnt || w_fetch_gnt;
  assign ls_rd_addr   = w_lsu_gnt   ? lsu_qaddr     :
                        w_fetch_gnt ? w_fetch_qaddr : '0;
  assign lsu_rvalid   = r_lsu_rv;
  assign line_wr_en   = r_rv;
  assign line_wr_idx  = r_ridx;
  assign line_wr_data = ls_rd_data;
  assign line_valid   = r_line_valid;
  assign line_base    = {r_line_tag, {LINE_OFS_W{1'b0}}};
  assign busy         = (r_state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_start_tag = w_fetch_tag;
    case (r_state)
      IDLE: begin
        if (fetch_req) begin
          w_state_nxt = FILL;
          w_start     = 1'b1;
        end
      end
      FILL: begin
        if (w_fetch_gnt && (r_issue_cnt == c_LAST_IDX)) begin
          w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (w_complete) begin
          if (w_pend_any) begin
            w_state_nxt = FILL;
            w_start     = 1'b1;
            w_start_tag = w_pend_tag;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    // A redirect overrides whatever the sequencer was doing.
    if (flush) begin
      w_state_nxt = FILL;
      w_start     = 1'b1;
      w_start_tag = w_fetch_tag;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_base_tag   <= '0;
      r_issue_cnt  <= '0;
      r_rv         <= 1'b0;
      r_ridx       <= '0;
      r_lsu_rv     <= 1'b0;
      r_pend_v     <= 1'b0;
      r_pend_tag   <= '0;
      r_line_valid <= 1'b0;
      r_line_tag   <= '0;
    end else begin
      r_lsu_rv <= w_lsu_gnt;
      // Data for a beat issued in the flush cycle belongs to the old line.
      r_rv     <= w_fetch_gnt && !flush;
      if (w_fetch_gnt) begin
        r_ridx      <= r_issue_cnt;
        r_issue_cnt <= r_issue_cnt + 1'b1;
      end
      if (w_start) begin
        r_base_tag  <= w_start_tag;
        r_issue_cnt <= '0;
      end

      if (flush || w_start) begin
        r_pend_v <= 1'b0;
      end else if (w_req_busy) begin
        r_pend_v   <= 1'b1;
        r_pend_tag <= w_fetch_tag;
      end

      // A back-to-back refill drops valid once it starts overwriting slot 0.
      if (flush) begin
        r_line_valid <= 1'b0;
      end else if (w_complete) begin
        r_line_valid <= 1'b1;
        r_line_tag   <= r_base_tag;
      end else if (w_start || (r_rv && (r_ridx == '0))) begin
        r_line_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_line_ctrl.sv
`default_nettype none
// ============================================================================
// tb_fetch_line_ctrl : scoreboard bench for fetch_line_ctrl (PC_W=8, STARVE_MAX=8)
// Revision: 1.0
// ============================================================================
module tb_fetch_line_ctrl;

  localparam int PC_W       = 8;
  localparam int STARVE_MAX = 8;

  logic         clk       = 1'b0;
  logic         reset     = 1'b0;
  logic         fetch_req = 1'b0;
  logic [7:0]   fetch_pc  = '0;
  logic         flush     = 1'b0;
  logic         lsu_req   = 1'b0;
  logic [5:0]   lsu_qaddr = '0;
  logic [127:0] ls_rd_data = '0;
  logic         lsu_gnt, lsu_rvalid, ls_rd_en, line_wr_en, line_valid, busy;
  logic [5:0]   ls_rd_addr;
  logic [1:0]   line_wr_idx;
  logic [127:0] line_wr_data;
  logic [7:0]   line_base;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {int cyc; logic [5:0] addr; bit lsu;} rd_t;
  typedef struct {int cyc; logic [1:0] idx; logic [127:0] data;} wr_t;
  rd_t rd_q[$];
  wr_t wr_q[$];
  int  rv_q[$];

  fetch_line_ctrl #(
    .PC_W       (PC_W),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .fetch_req    (fetch_req),
    .fetch_pc     (fetch_pc),
    .flush        (flush),
    .lsu_req      (lsu_req),
    .lsu_qaddr    (lsu_qaddr),
    .lsu_gnt      (lsu_gnt),
    .lsu_rvalid   (lsu_rvalid),
    .ls_rd_en     (ls_rd_en),
    .ls_rd_addr   (ls_rd_addr),
    .ls_rd_data   (ls_rd_data),
    .line_wr_en   (line_wr_en),
    .line_wr_idx  (line_wr_idx),
    .line_wr_data (line_wr_data),
    .line_valid   (line_valid),
    .line_base    (line_base),
    .busy         (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [127:0] qw(input logic [5:0] a);
    logic [31:0] w;
    w = {26'h0, a};
    return {32'hA000_0000 | w, 32'hB000_0000 | w, 32'hC000_0000 | w, 32'hD000_0000 | w};
  endfunction

  // Local store: data for the address read in one cycle appears the next.
  always @(posedge clk) if (ls_rd_en) ls_rd_data <= qw(ls_rd_addr);

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic exp_rd(input int c, input logic [5:0] a, input bit l);
    rd_q.push_back('{c, a, l});
  endtask
  task automatic exp_wr(input int c, input logic [1:0] i, input logic [127:0] d);
    wr_q.push_back('{c, i, d});
  endtask
  task automatic exp_rv(input int c);
    rv_q.push_back(c);
  endtask

  // Scoreboard monitor: matches every DUT read, line write and LSU return.
  always @(negedge clk) begin : mon
    rd_t er;
    wr_t ew;
    int  ev;
    while (rd_q.size() > 0 && rd_q[0].cyc < cyc) begin
      checks++; errors++;
      $display("FAIL rd_missing cyc=%0d got=none want_addr=%0h", rd_q[0].cyc, rd_q[0].addr);
      void'(rd_q.pop_front());
    end
    while (wr_q.size() > 0 && wr_q[0].cyc < cyc) begin
      checks++; errors++;
      $display("FAIL wr_missing cyc=%0d got=none want_idx=%0d", wr_q[0].cyc, wr_q[0].idx);
      void'(wr_q.pop_front());
    end
    while (rv_q.size() > 0 && rv_q[0] < cyc) begin
      checks++; errors++;
      $display("FAIL rvalid_missing cyc=%0d got=0 want=1", rv_q[0]);
      void'(rv_q.pop_front());
    end
    if (ls_rd_en) begin
      if (rd_q.size() == 0 || rd_q[0].cyc != cyc) begin
        checks++; errors++;
        $display("FAIL rd_unexpected cyc=%0d got_addr=%0h want=none", cyc, ls_rd_addr);
      end else begin
        er = rd_q.pop_front();
        chk("rd_addr", 128'(ls_rd_addr), 128'(er.addr));
        chk("rd_owner_lsu", 128'(lsu_gnt), 128'(er.lsu));
      end
    end
    if (line_wr_en) begin
      if (wr_q.size() == 0 || wr_q[0].cyc != cyc) begin
        checks++; errors++;
        $display("FAIL wr_unexpected cyc=%0d got_idx=%0d want=none", cyc, line_wr_idx);
      end else begin
        ew = wr_q.pop_front();
        chk("wr_idx", 128'(line_wr_idx), 128'(ew.idx));
        chk("wr_data", line_wr_data, ew.data);
      end
    end
    if (lsu_rvalid) begin
      if (rv_q.size() == 0 || rv_q[0] != cyc) begin
        checks++; errors++;
        $display("FAIL rvalid_unexpected cyc=%0d got=1 want=0", cyc);
      end else begin
        ev = rv_q.pop_front();
        chk("rvalid_cycle", 128'(cyc), 128'(ev));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_cyc(input int n);
    while (cyc < n) tick();
  endtask
  task automatic at_neg(input int n);
    wait_cyc(n);
    @(negedge clk);
  endtask
  task automatic do_reset();
    fetch_req = 1'b0; flush = 1'b0; lsu_req = 1'b0;
    reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int c0;
    // Reset state
    tick();
    @(negedge clk);
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_line_valid", 128'(line_valid), 128'(0));
    chk("rst_line_base", 128'(line_base), 128'(0));
    chk("rst_ls_rd_en", 128'(ls_rd_en), 128'(0));
    chk("rst_line_wr_en", 128'(line_wr_en), 128'(0));
    chk("rst_lsu_rvalid", 128'(lsu_rvalid), 128'(0));

    // Basic refill of pc 0x13 -> base 0x10, qaddr 4..7
    do_reset();
    tick(); c0 = cyc;
    fetch_req = 1'b1; fetch_pc = 8'h13;
    for (int i = 0; i < 4; i++) begin
      exp_rd(c0 + 1 + i, 6'(4 + i), 1'b0);
      exp_wr(c0 + 2 + i, 2'(i), qw(6'(4 + i)));
    end
    tick(); fetch_req = 1'b0;
    at_neg(c0 + 1); chk("t1_busy_c1", 128'(busy), 128'(1));
    at_neg(c0 + 5); chk("t1_valid_c5", 128'(line_valid), 128'(0));
    chk("t1_busy_c5", 128'(busy), 128'(1));
    at_neg(c0 + 6); chk("t1_valid_c6", 128'(line_valid), 128'(1));
    chk("t1_base", 128'(line_base), 128'(8'h10));
    chk("t1_idle_c6", 128'(busy), 128'(0));

    // Starvation bound: LSU wins 8 FILL cycles, then one fetch beat
    do_reset();
    tick(); c0 = cyc;
    fetch_req = 1'b1; fetch_pc = 8'h00; lsu_req = 1'b1; lsu_qaddr = 6'h3F;
    for (int c = 0; c <= 37; c++) begin
      if (c > 0 && (c % 9) == 0) begin
        exp_rd(c0 + c, 6'(c / 9 - 1), 1'b0);
        exp_wr(c0 + c + 1, 2'(c / 9 - 1), qw(6'(c / 9 - 1)));
      end else begin
        exp_rd(c0 + c, 6'h3F, 1'b1);
        exp_rv(c0 + c + 1);
      end
    end
    tick(); fetch_req = 1'b0;
    at_neg(c0 + 37); chk("t2_valid_c37", 128'(line_valid), 128'(0));
    chk("t2_busy_c37", 128'(busy), 128'(1));
    wait_cyc(c0 + 38); lsu_req = 1'b0;
    @(negedge clk);
    chk("t2_valid_c38", 128'(line_valid), 128'(1));
    chk("t2_base", 128'(line_base), 128'(8'h00));

    // Flush to 0x40 in cycle 3 of refill at 0
    do_reset();
    tick(); c0 = cyc;
    fetch_req = 1'b1; fetch_pc = 8'h00;
    for (int i = 0; i < 3; i++) exp_rd(c0 + 1 + i, 6'(i), 1'b0);
    exp_wr(c0 + 2, 2'd0, qw(6'd0));
    exp_wr(c0 + 3, 2'd1, qw(6'd1));
    for (int i = 0; i < 4; i++) begin
      exp_rd(c0 + 4 + i, 6'(16 + i), 1'b0);
      exp_wr(c0 + 5 + i, 2'(i), qw(6'(16 + i)));
    end
    tick(); fetch_req = 1'b0;
    wait_cyc(c0 + 3); flush = 1'b1; fetch_pc = 8'h40;
    tick(); flush = 1'b0;
    at_neg(c0 + 4); chk("t3_busy_c4", 128'(busy), 128'(1));
    at_neg(c0 + 8); chk("t3_valid_c8", 128'(line_valid), 128'(0));
    at_neg(c0 + 9); chk("t3_valid_c9", 128'(line_valid), 128'(1));
    chk("t3_base", 128'(line_base), 128'(8'h40));

    // Pending request: 0x20 then 0x30 while busy
    do_reset();
    tick(); c0 = cyc;
    fetch_req = 1'b1; fetch_pc = 8'h20;
    for (int i = 0; i < 4; i++) begin
      exp_rd(c0 + 1 + i, 6'(8 + i), 1'b0);
      exp_wr(c0 + 2 + i, 2'(i), qw(6'(8 + i)));
    end
    for (int i = 0; i < 4; i++) begin
      exp_rd(c0 + 6 + i, 6'(12 + i), 1'b0);
      exp_wr(c0 + 7 + i, 2'(i), qw(6'(12 + i)));
    end
    tick(); fetch_req = 1'b0;
    wait_cyc(c0 + 2); fetch_req = 1'b1; fetch_pc = 8'h30;
    tick(); fetch_req = 1'b0;
    at_neg(c0 + 6); chk("t4_valid_c6", 128'(line_valid), 128'(1));
    chk("t4_base_c6", 128'(line_base), 128'(8'h20));
    chk("t4_busy_c6", 128'(busy), 128'(1));
    at_neg(c0 + 11); chk("t4_valid_c11", 128'(line_valid), 128'(1));
    chk("t4_base_c11", 128'(line_base), 128'(8'h30));
    chk("t4_idle_c11", 128'(busy), 128'(0));

    // Async reset in DRAIN
    do_reset();
    tick(); c0 = cyc;
    fetch_req = 1'b1; fetch_pc = 8'h50;
    for (int i = 0; i < 4; i++) exp_rd(c0 + 1 + i, 6'(20 + i), 1'b0);
    for (int i = 0; i < 3; i++) exp_wr(c0 + 2 + i, 2'(i), qw(6'(20 + i)));
    tick(); fetch_req = 1'b0;
    wait_cyc(c0 + 5);
    chk("t5_in_drain_wr", 128'(line_wr_en), 128'(1));
    #1; reset = 1'b0;
    #1;
    chk("t5_rst_busy", 128'(busy), 128'(0));
    chk("t5_rst_wr_en", 128'(line_wr_en), 128'(0));
    chk("t5_rst_rd_en", 128'(ls_rd_en), 128'(0));
    chk("t5_rst_valid", 128'(line_valid), 128'(0));
    chk("t5_rst_base", 128'(line_base), 128'(0));
    repeat (2) tick();
    reset = 1'b1;
    repeat (4) tick();
    @(negedge clk);
    chk("t5_post_busy", 128'(busy), 128'(0));
    chk("t5_post_valid", 128'(line_valid), 128'(0));

    // LSU request in IDLE
    do_reset();
    tick(); c0 = cyc;
    lsu_req = 1'b1; lsu_qaddr = 6'h2A;
    exp_rd(c0, 6'h2A, 1'b1);
    exp_rv(c0 + 1);
    #1;
    chk("t6_gnt", 128'(lsu_gnt), 128'(1));
    chk("t6_addr", 128'(ls_rd_addr), 128'(6'h2A));
    tick(); lsu_req = 1'b0;
    chk("t6_rvalid", 128'(lsu_rvalid), 128'(1));
    chk("t6_no_wr", 128'(line_wr_en), 128'(0));
    repeat (3) tick();

    chk("queues_drained", 128'(rd_q.size() + wr_q.size() + rv_q.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
